// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: operand tile buffers,
// array clear pulse and skewed A/B wavefronts. Macro SYSTOLIC_SEQ_CTRL_ACCUM_EN adds a clear-less accumulate start.
module systolic_seq_ctrl #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 16,
    parameter int unsigned CW = $clog2(3*N-1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [DW-1:0]        wr_data,
`ifdef SYSTOLIC_SEQ_CTRL_ACCUM_EN
    input  logic                 accum,
`endif
    input  logic                 start,
    output logic [N*DW-1:0]      a_feed,
    output logic [N*DW-1:0]      b_feed,
    output logic                 pe_clr,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IW   = $clog2(N);
    localparam int unsigned LAST = 3*N - 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FEED  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          pe_clr_d, busy_d, done_d;
    logic          wr_ok;

    logic [DW-1:0] a_buf [N][N];
    logic [DW-1:0] b_buf [N][N];

    // Buffers only accept writes while the array is not consuming them.
    assign wr_ok = wr_en && (state == IDLE || state == DONE)
                && ({1'b0, wr_row} < (IW+1)'(N))
                && ({1'b0, wr_col} < (IW+1)'(N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (wr_sel) begin
                b_buf[wr_row][wr_col] <= wr_data;
            end else begin
                a_buf[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // State, feed counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            pe_clr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            pe_clr <= pe_clr_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    // Next state; status outputs are decoded from the next state so they line up with it.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CLEAR;
`ifdef SYSTOLIC_SEQ_CTRL_ACCUM_EN
                    if (accum) begin
                        state_d = FEED;
                    end
`endif
                    cnt_d = '0;
                end
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt == CW'(LAST)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pe_clr_d = (state_d == CLEAR);
        busy_d   = (state_d == CLEAR) || (state_d == FEED);
        done_d   = (state_d == DONE);
    end

    // Skewed wavefronts: row i (column j) is delayed by i (j) cycles.
    always_comb begin
        a_feed = '0;
        b_feed = '0;
        if (state == FEED) begin
            for (int i = 0; i < N; i++) begin
                if (int'(cnt) >= i && int'(cnt) - i < N) begin
                    a_feed[i*DW +: DW] = a_buf[IW'(i)][IW'(int'(cnt) - i)];
                    b_feed[i*DW +: DW] = b_buf[IW'(int'(cnt) - i)][IW'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: a behavioural PE array consumes the feeds and a
// scoreboard checks the C matrix and done latency whenever done rises.
module tb_systolic_seq_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned MW = N*N*DW;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic          wr_sel  = 1'b0;
    logic [IW-1:0] wr_row  = '0;
    logic [IW-1:0] wr_col  = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start   = 1'b0;
`ifdef SYSTOLIC_SEQ_CTRL_ACCUM_EN
    logic          accum   = 1'b0;
`endif
    logic [N*DW-1:0] a_feed, b_feed;
    logic            pe_clr, busy, done;

    systolic_seq_ctrl #(.N(N), .DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
`ifdef SYSTOLIC_SEQ_CTRL_ACCUM_EN
        .accum   (accum),
`endif
        .start   (start),
        .a_feed  (a_feed),
        .b_feed  (b_feed),
        .pe_clr  (pe_clr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_cnt = 0;
    int clr_cnt  = 0;
    logic done_prev = 1'b0;

    logic [MW-1:0] exp_c[$];
    int            exp_cyc[$];
    logic [MW-1:0] last_exp = '0;

    logic [DW-1:0] sa [N][N];
    logic [DW-1:0] sb [N][N];

    // Behavioural PE array: A moves east, B moves south, C accumulates.
    logic [DW-1:0] pa [N][N];
    logic [DW-1:0] pb [N][N];
    logic [DW-1:0] mc [N][N];
    logic [DW-1:0] ain [N][N];
    logic [DW-1:0] bin [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ain[i][0] = a_feed[i*DW +: DW];
            bin[0][i] = b_feed[i*DW +: DW];
            for (int j = 1; j < N; j++) begin
                ain[i][j] = pa[i][j-1];
                bin[j][i] = pb[j-1][i];
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (pe_clr) begin
                    mc[i][j] <= '0;
                    pa[i][j] <= '0;
                    pb[i][j] <= '0;
                end else begin
                    mc[i][j] <= mc[i][j] + ain[i][j] * bin[i][j];
                    pa[i][j] <= ain[i][j];
                    pb[i][j] <= bin[i][j];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] flat_c();
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[(i*N+j)*DW +: DW] = mc[i][j];
        return r;
    endfunction

    function automatic logic [MW-1:0] matmul(input logic [MW-1:0] base);
        logic [MW-1:0] r;
        logic [DW-1:0] s;
        r = base;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = r[(i*N+j)*DW +: DW];
                for (int k = 0; k < N; k++) s = s + sa[i][k] * sb[k][j];
                r[(i*N+j)*DW +: DW] = s;
            end
        end
        return r;
    endfunction

    // Scoreboard monitor: every rising done must match the oldest expected run.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (pe_clr) clr_cnt++;
        if (done && !done_prev) begin
            if (exp_c.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want no pending run at cycle %0d", cyc);
            end else begin
                chk("c_result", flat_c(), exp_c.pop_front());
                chk("done_latency", MW'(cyc), MW'(exp_cyc.pop_front()));
            end
        end
        done_prev = done;
    end

    function automatic logic [DW-1:0] pat(input int kind, input int r, input int c);
        case (kind)
            0:       return (r == c) ? DW'(1) : DW'(0);
            1:       return DW'(4*r + c + 1);
            2:       return DW'(2);
            3:       return DW'(r + c);
            default: return (r == c) ? DW'(3) : DW'(0);
        endcase
    endfunction

    task automatic wr_el(input logic sel, input int r, input int c, input logic [DW-1:0] v);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel) sb[r][c] = v; else sa[r][c] = v;
    endtask

    task automatic load(input logic sel, input int kind);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wr_el(sel, r, c, pat(kind, r, c));
    endtask

    // Start a run; wa also writes A[0][0]=7 on the same edge as start.
    task automatic do_start(input bit acc, input int lat, input bit wa);
        logic [MW-1:0] e;
        @(negedge clk);
        start = 1'b1;
`ifdef SYSTOLIC_SEQ_CTRL_ACCUM_EN
        accum = acc;
`endif
        if (wa) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = DW'(7);
            sa[0][0] = DW'(7);
        end
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
`ifdef SYSTOLIC_SEQ_CTRL_ACCUM_EN
        accum = 1'b0;
`endif
        e = matmul(acc ? last_exp : '0);
        last_exp = e;
        exp_c.push_back(e);
        exp_cyc.push_back(cyc + lat);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_c.size() != 0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("done_pending", MW'(exp_c.size()), '0);
    endtask

    initial begin
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                sa[r][c] = '0;
                sb[r][c] = '0;
            end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   MW'(busy),   '0);
        chk("rst_done",   MW'(done),   '0);
        chk("rst_pe_clr", MW'(pe_clr), '0);
        chk("rst_a_feed", MW'(a_feed), '0);
        chk("rst_b_feed", MW'(b_feed), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Buffers come out of reset as zero.
        do_start(1'b0, 11, 1'b0);
        wait_done();

        // Identity A, sequential B; row 2 of A feed carries its 1 only at t = 4.
        load(1'b0, 0);
        load(1'b1, 1);
        do_start(1'b0, 11, 1'b0);
        for (int t = 0; t < 3*N-2; t++) begin
            @(posedge clk); #1;
            chk($sformatf("a_feed2_t%0d", t), MW'(a_feed[2*DW +: DW]), (t == 4) ? MW'(1) : MW'(0));
        end
        wait_done();
        chk("done_held", MW'(done), MW'(1));
        chk("busy_in_done", MW'(busy), '0);

        // All twos: busy spans 11 cycles, pe_clr exactly one.
        load(1'b0, 2);
        load(1'b1, 2);
        busy_cnt = 0;
        clr_cnt  = 0;
        do_start(1'b0, 11, 1'b0);
        wait_done();
        chk("busy_cycles", MW'(busy_cnt), MW'(11));
        chk("pe_clr_cycles", MW'(clr_cnt), MW'(1));

`ifdef SYSTOLIC_SEQ_CTRL_ACCUM_EN
        // Accumulate on top of the all-twos result, no clear.
        clr_cnt = 0;
        do_start(1'b1, 10, 1'b0);
        wait_done();
        chk("accum_pe_clr", MW'(clr_cnt), '0);
`endif

        // A second start during FEED must not restart the run.
        do_start(1'b0, 11, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        // Write during FEED is dropped.
        do_start(1'b0, 11, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = DW'(7);
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_done();

        // The same write together with start in DONE lands and is used.
        do_start(1'b0, 11, 1'b1);
        wait_done();

        // Reset in the middle of FEED (t = 5).
        do_start(1'b0, 11, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        chk("mid_busy_before", MW'(busy), MW'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   MW'(busy),   '0);
        chk("mid_rst_done",   MW'(done),   '0);
        chk("mid_rst_pe_clr", MW'(pe_clr), '0);
        chk("mid_rst_a_feed", MW'(a_feed), '0);
        chk("mid_rst_b_feed", MW'(b_feed), '0);
        exp_c.delete();
        exp_cyc.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                sa[r][c] = '0;
                sb[r][c] = '0;
            end
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh load after reset.
        load(1'b0, 3);
        load(1'b1, 4);
        do_start(1'b0, 11, 1'b0);
        wait_done();

        repeat (4) @(posedge clk);
        #1;
        chk("final_queue", MW'(exp_c.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of MAC PEs. Each PE forwards A rightward and B downward with one register stage, and accumulates C.
- Holds the A and B operand tiles in internal register buffers, loaded through a simple write port.
- On start: clears the array, then drives skewed operand wavefronts into the array's west edge (A) and north edge (B).
- Flags done when every PE holds its final C value.

Parameters:
- N, 4, array dimension (rows = cols = inner dimension K).
- DW, 16, operand data width.
- CW, $clog2(3*N-1), feed counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  operand buffer write strobe.
- wr_sel  in  1  0 = A buffer, 1 = B buffer.
- wr_row  in  $clog2(N)  element row index.
- wr_col  in  $clog2(N)  element column index.
- wr_data  in  DW  element value.
- start  in  1  start-compute pulse.
- a_feed  out  N*DW  west-edge A inputs; slice i drives array row i.
- b_feed  out  N*DW  north-edge B inputs; slice j drives array column j.
- pe_clr  out  1  active-high array clear, wired to the PE rst inputs.
- busy  out  1  high in CLEAR and FEED.
- done  out  1  C results valid; held until the next start.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, counter = 0, both buffers = 0.
  - pe_clr = 0, busy = 0, done = 0, a_feed = 0, b_feed = 0.
- States: IDLE, CLEAR, FEED, DONE.
- IDLE / DONE:
  - wr_en writes buf[wr_sel][wr_row][wr_col] = wr_data at the clock edge.
  - start sampled high -> CLEAR. done drops on that same edge.
  - If wr_en and start are both high on one edge, the write lands first; the new value is used in this run.
- CLEAR:
  - Lasts exactly 1 cycle. pe_clr = 1 (registered, glitch-free), busy = 1.
  - Next state FEED, counter = 0.
- FEED:
  - Lasts 3N-2 cycles; counter t runs 0..3N-3. busy = 1, pe_clr = 0.
  - a_feed slice i = A[i][t-i] when 0 <= t-i <= N-1, else 0.
  - b_feed slice j = B[t-j][j] when 0 <= t-j <= N-1, else 0.
  - Feeds are decoded combinationally from the registered state and counter. They are 0 outside FEED.
  - At t = 3N-3 the next state is DONE.
  - Timing: PE(i,j) sees A[i][k] and B[k][j] together at cycle t = i+j+k. The last product reaches PE(N-1,N-1) at t = 3N-3.
- DONE:
  - done = 1, busy = 0. The array holds C = A x B; no further feed.
- Latency: start sampled at edge E0 -> done high after edge E(3N-1). For N = 4 that is 11 edges.
- Ignored inputs: start in CLEAR or FEED is ignored (no restart, no queueing). wr_en in CLEAR or FEED is ignored, so the buffers are stable during compute.
- Arithmetic: no arithmetic in this block. Products and sums wrap mod 2^DW inside the PEs.
- Reset mid-FEED: immediate return to IDLE, feeds = 0, done = 0. The array keeps partial sums until the next CLEAR.
- Out-of-range indices: cannot occur, since N is a power of two. For non-power-of-two N, wr_row or wr_col >= N drops the write.

Optional Feature:
- Macro: SYSTOLIC_SEQ_CTRL_ACCUM_EN.
- Defined:
  - Adds input port accum (1 bit).
  - start with accum = 1 goes IDLE/DONE -> FEED directly and skips CLEAR. pe_clr stays 0, so C += A x B across tiles.
  - Latency with accum = 1 is 3N-2 edges.
  - start with accum = 0 behaves exactly as the base design.
- Not defined: no accum port; every start passes through CLEAR.

Test Plan:
- Identity product: load A = I, B[r][c] = 4r+c+1, start -> done after 11 edges; PE(r,c).C1 = 4r+c+1. During FEED, a_feed slice 2 is nonzero only at t = 4, where it equals 1.
- All-twos product: load A = B = all 2, start -> every C1 = 16. busy is high for exactly 11 cycles; pe_clr is high for exactly 1 cycle.
- Ignored start: pulse start again at FEED t = 3 -> no restart; done still rises 11 edges after the first start.
- Ignored write: wr_en writing A[0][0] = 7 at FEED t = 1 is dropped -> result unchanged. The same write in DONE followed by a new start is used.
- Reset mid-run: rst_n low at FEED t = 5 -> busy = 0, done = 0, feeds = 0 immediately. A fresh load and start completes with correct results.
- Accumulate (ACCUM_EN): all-twos run, then start with accum = 1 -> every C1 = 32, done after 10 edges, pe_clr never asserted.
